ctr_stream_engine: RTL and testbench

CTR_STREAM_ENGINE -- requirements
Module: ctr_stream_engine

---
 rtl/ctr_stream_engine_if.sv | 37 +++
 rtl/ctr_stream_engine.sv | 132 +++++++++++++
 tb/tb_ctr_stream_engine.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctr_stream_engine_if.sv
// ctr_stream_engine_if: control, AES handshake and plaintext/ciphertext stream bundle for ctr_stream_engine.
// slave is the engine's view; master is the view of whatever drives it.
interface ctr_stream_engine_if #(
    parameter int MAX_BLOCKS = 16
);
    localparam int NBW = $clog2(MAX_BLOCKS + 1);
    logic           start;
    logic [127:0]   iv;
    logic [NBW-1:0] num_blocks;
    logic [3:0]     last_bytes;
    logic           abort;
    logic           busy;
    logic           done;
    logic           aes_req;
    logic [127:0]   aes_blk;
    logic           aes_ack;
    logic           aes_ks_valid;
    logic [127:0]   aes_ks;
    logic           pt_valid;
    logic [127:0]   pt_data;
    logic           pt_ready;
    logic           ct_valid;
    logic [127:0]   ct_data;
    logic [15:0]    ct_keep;
    logic           ct_last;
    logic           ct_ready;
    modport slave (
        input  start, iv, num_blocks, last_bytes, abort, aes_ack, aes_ks_valid, aes_ks,
               pt_valid, pt_data, ct_ready,
        output busy, done, aes_req, aes_blk, pt_ready, ct_valid, ct_data, ct_keep, ct_last
    );
    modport master (
        output start, iv, num_blocks, last_bytes, abort, aes_ack, aes_ks_valid, aes_ks,
               pt_valid, pt_data, ct_ready,
        input  busy, done, aes_req, aes_blk, pt_ready, ct_valid, ct_data, ct_keep, ct_last
    );
endinterface

// File: rtl/ctr_stream_engine.sv
// ctr_stream_engine: issues AES-CTR counter blocks under a keystream credit limit and XORs
// the returned keystream onto the plaintext stream, trimming the final partial block.
module ctr_stream_engine #(
    parameter int CTR_W      = 32,
    parameter int MAX_BLOCKS = 16,
    parameter int KS_DEPTH   = 2
) (
    input logic                clk,
    input logic                rst_n,
    ctr_stream_engine_if.slave bus
);
    localparam int NBW = $clog2(MAX_BLOCKS + 1);
    localparam int CW  = $clog2(KS_DEPTH + 1);
    localparam int PW  = KS_DEPTH > 1 ? $clog2(KS_DEPTH) : 1;
    // (1 << 128) - 1 folds to all ones, so CTR_W = 128 needs no special case
    localparam logic [127:0]  CTR_MASK = (128'd1 << CTR_W) - 128'd1;
    localparam logic [CW:0]   DEPTH    = (CW + 1)'(KS_DEPTH);
    localparam logic [PW-1:0] LAST_P   = PW'(KS_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e         state_q, state_d;
    logic [127:0]   ctr_q;
    logic [NBW-1:0] nblk_q, issued_q, consumed_q;
    logic [3:0]     lbytes_q;
    logic [CW-1:0]  outst_q, cnt_q;
    logic [PW-1:0]  wp_q, rp_q;
    logic [127:0]   mem_q [KS_DEPTH];
    logic           ct_valid_q, ct_last_q, zdone_q;
    logic [127:0]   ct_data_q;
    logic [15:0]    ct_keep_q;

    logic         go, req, fire, push, pt_ready, pop, is_last, ct_xfer;
    logic [15:0]  keep;
    logic [127:0] dmask;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return p == LAST_P ? '0 : p + PW'(1);
    endfunction

    // a new start waits until every response of an aborted message has drained
    assign go       = state_q == IDLE && bus.start && !bus.abort && outst_q == '0;
    assign req      = state_q == RUN && issued_q < nblk_q && ({1'b0, outst_q} + {1'b0, cnt_q}) < DEPTH;
    assign fire     = req && bus.aes_ack;
    assign push     = bus.aes_ks_valid && state_q == RUN && !bus.abort;
    assign pt_ready = state_q == RUN && cnt_q != '0 && (!ct_valid_q || bus.ct_ready);
    assign pop      = bus.pt_valid && pt_ready;
    assign is_last  = consumed_q == nblk_q - NBW'(1);
    assign ct_xfer  = ct_valid_q && bus.ct_ready;
    assign keep     = is_last ? ~(16'hFFFF >> (lbytes_q == 4'd0 ? 5'd16 : {1'b0, lbytes_q})) : 16'hFFFF;

    always_comb begin
        dmask = '0;
        for (int b = 0; b < 16; b++) dmask[8*b +: 8] = {8{keep[b]}};
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort) state_d = IDLE;
        else if (go && bus.num_blocks != '0) state_d = RUN;
        else if (state_q == RUN && pop && is_last) state_d = DRAIN;
        else if (state_q == DRAIN && ct_xfer) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q      <= '0;
            nblk_q     <= '0;
            lbytes_q   <= '0;
            issued_q   <= '0;
            consumed_q <= '0;
            outst_q    <= '0;
            cnt_q      <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            for (int i = 0; i < KS_DEPTH; i++) mem_q[i] <= '0;
            ct_valid_q <= 1'b0;
            ct_data_q  <= '0;
            ct_keep_q  <= '0;
            ct_last_q  <= 1'b0;
            zdone_q    <= 1'b0;
        end else begin
            if (go) begin
                ctr_q      <= bus.iv;
                nblk_q     <= bus.num_blocks;
                lbytes_q   <= bus.last_bytes;
                issued_q   <= '0;
                consumed_q <= '0;
            end else if (fire) begin
                ctr_q    <= (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
                issued_q <= issued_q + NBW'(1);
            end
            if (pop) consumed_q <= consumed_q + NBW'(1);
            outst_q <= outst_q + CW'(fire) - CW'(bus.aes_ks_valid && outst_q != '0);
            if (bus.abort) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wp_q] <= bus.aes_ks;
                    wp_q        <= ptr_inc(wp_q);
                end
                if (pop) rp_q <= ptr_inc(rp_q);
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
            if (bus.abort) ct_valid_q <= 1'b0;
            else if (pop) begin
                ct_valid_q <= 1'b1;
                ct_data_q  <= (bus.pt_data ^ mem_q[rp_q]) & dmask;
                ct_keep_q  <= keep;
                ct_last_q  <= is_last;
            end else if (ct_xfer) ct_valid_q <= 1'b0;
            zdone_q <= go && bus.num_blocks == '0;
        end
    end

    assign bus.busy     = state_q != IDLE;
    assign bus.done     = zdone_q || (state_q == DRAIN && ct_xfer && !bus.abort);
    assign bus.aes_req  = req;
    assign bus.aes_blk  = ctr_q;
    assign bus.pt_ready = pt_ready;
    assign bus.ct_valid = ct_valid_q;
    assign bus.ct_data  = ct_data_q;
    assign bus.ct_keep  = ct_keep_q;
    assign bus.ct_last  = ct_last_q;
endmodule

// File: tb/tb_ctr_stream_engine.sv
// tb_ctr_stream_engine: randomized bench for ctr_stream_engine with a stub AES core and a
// message-level model of counter sequencing, XOR and final-block trimming.
module tb_ctr_stream_engine;
    localparam int NBW = 5;
    localparam int KSD = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ctr_stream_engine_if #(.MAX_BLOCKS(16)) bus ();
    ctr_stream_engine #(.CTR_W(32), .MAX_BLOCKS(16), .KS_DEPTH(KSD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int vecs = 0;
    int errs = 0;
    logic [127:0] pend[$];
    logic [127:0] blk_log[$];
    int msg_acks = 0;
    int ack_budget = 1 << 30;
    bit ks_en = 1'b1;
    bit ks_zero = 1'b0;
    bit pt_ff = 1'b0;
    logic [127:0] last_ct;
    logic [15:0] last_keep;

    function automatic logic [127:0] aes_e(input logic [127:0] x);
        return {x[100:0], x[127:101]} ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    endfunction

    function automatic logic [127:0] ctr_at(input logic [127:0] iv_v, input int k);
        return {iv_v[127:32], iv_v[31:0] + 32'(k)};
    endfunction

    function automatic logic [127:0] exp_data(input logic [127:0] pt, input logic [127:0] ks, input bit lst, input int lb);
        logic [127:0] r;
        int n;
        n = lst ? (lb == 0 ? 16 : lb) : 16;
        r = pt ^ ks;
        for (int i = n; i < 16; i++) r[127-8*i -: 8] = 8'h00;
        return r;
    endfunction

    function automatic logic [15:0] exp_keep(input bit lst, input int lb);
        logic [15:0] k;
        int n;
        n = lst ? (lb == 0 ? 16 : lb) : 16;
        k = '0;
        for (int i = 0; i < n; i++) k[15-i] = 1'b1;
        return k;
    endfunction

    // stub AES core: acks at random, answers in request order after a random delay
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            bus.aes_ack = 1'b0;
            bus.aes_ks_valid = 1'b0;
            bus.aes_ks = '0;
        end else begin
            if (ks_en && pend.size() > 0 && $urandom % 3 != 0) begin
                bus.aes_ks_valid = 1'b1;
                bus.aes_ks = pend.pop_front();
            end else bus.aes_ks_valid = 1'b0;
            bus.aes_ack = ack_budget > 0 && $urandom % 4 != 0;
            if (bus.aes_req && bus.aes_ack) begin
                pend.push_back(ks_zero ? 128'd0 : aes_e(bus.aes_blk));
                blk_log.push_back(bus.aes_blk);
                msg_acks++;
                ack_budget--;
            end
        end
    end

    task automatic run_msg(input logic [127:0] iv_v, input int nb, input int lb, input int stall, input int stop_after);
        logic [127:0] pts[$];
        logic [127:0] ks, h_data;
        logic [15:0] h_keep;
        bit held, lst;
        logic h_last;
        int pi, oi, cyc, target;
        pi = 0; oi = 0; cyc = 0; held = 0;
        target = stop_after > 0 ? stop_after : nb;
        for (int k = 0; k < nb; k++) pts.push_back(pt_ff ? '1 : {$urandom, $urandom, $urandom, $urandom});
        blk_log.delete();
        msg_acks = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.iv = iv_v; bus.num_blocks = NBW'(nb); bus.last_bytes = 4'(lb);
        @(negedge clk);
        bus.start = 1'b0; bus.iv = {$urandom, $urandom, $urandom, $urandom};
        bus.last_bytes = 4'($urandom);
        #1;
        vecs++;
        if (bus.busy !== 1'b1) begin errs++; $display("FAIL busy_after_start: got %b want 1", bus.busy); end
        while (oi < target && cyc < 3000) begin
            bus.pt_valid = pi < nb && $urandom % 4 != 0;
            if (pi < nb) bus.pt_data = pts[pi];
            bus.ct_ready = cyc >= stall && $urandom % 3 != 0;
            #1;
            vecs++;
            if (msg_acks - pi > KSD) begin
                errs++; $display("FAIL credit: issued-consumed %0d want <= %0d", msg_acks - pi, KSD);
            end
            if (held) begin
                vecs++;
                if ({bus.ct_valid, bus.ct_data, bus.ct_keep, bus.ct_last} !== {1'b1, h_data, h_keep, h_last}) begin
                    errs++; $display("FAIL ct_hold: got %b %h %h %b want 1 %h %h %b", bus.ct_valid, bus.ct_data, bus.ct_keep, bus.ct_last, h_data, h_keep, h_last);
                end
            end
            if (bus.ct_valid && bus.ct_ready) begin
                lst = oi == nb - 1;
                ks = ks_zero ? 128'd0 : aes_e(ctr_at(iv_v, oi));
                vecs++;
                if (bus.ct_data !== exp_data(pts[oi], ks, lst, lb)) begin
                    errs++; $display("FAIL ct_data[%0d]: got %h want %h", oi, bus.ct_data, exp_data(pts[oi], ks, lst, lb));
                end
                vecs++;
                if ({bus.ct_keep, bus.ct_last, bus.done} !== {exp_keep(lst, lb), lst, lst}) begin
                    errs++; $display("FAIL ct_keep_last_done[%0d]: got %h %b %b want %h %b %b", oi, bus.ct_keep, bus.ct_last, bus.done, exp_keep(lst, lb), lst, lst);
                end
                last_ct = bus.ct_data;
                last_keep = bus.ct_keep;
                oi++;
            end else begin
                vecs++;
                if (bus.done !== 1'b0) begin errs++; $display("FAIL done_idle: got %b want 0", bus.done); end
            end
            held = bus.ct_valid && !bus.ct_ready;
            h_data = bus.ct_data; h_keep = bus.ct_keep; h_last = bus.ct_last;
            if (bus.pt_valid && bus.pt_ready) pi++;
            cyc++;
            if (oi < target) @(negedge clk);
        end
        vecs++;
        if (oi < target) begin errs++; $display("FAIL msg_timeout: got %0d blocks want %0d", oi, target); end
        if (stop_after == 0) begin
            vecs++;
            if (blk_log.size() != nb) begin errs++; $display("FAIL req_count: got %0d want %0d", blk_log.size(), nb); end
            for (int k = 0; k < blk_log.size(); k++) begin
                vecs++;
                if (blk_log[k] !== ctr_at(iv_v, k)) begin
                    errs++; $display("FAIL aes_blk[%0d]: got %h want %h", k, blk_log[k], ctr_at(iv_v, k));
                end
            end
            @(negedge clk);
            bus.pt_valid = 1'b0; bus.ct_ready = 1'b0;
            #1;
            vecs++;
            if (bus.busy !== 1'b0) begin errs++; $display("FAIL busy_after_done: got %b want 0", bus.busy); end
        end
    endtask

    task automatic check_all_zero(input string tag);
        vecs++;
        if ({bus.busy, bus.done, bus.aes_req, bus.pt_ready, bus.ct_valid, bus.ct_last} !== 6'b0) begin
            errs++; $display("FAIL %s_ctrl: got %b want 000000", tag, {bus.busy, bus.done, bus.aes_req, bus.pt_ready, bus.ct_valid, bus.ct_last});
        end
        vecs++;
        if ({bus.ct_data, bus.aes_blk, bus.ct_keep} !== '0) begin
            errs++; $display("FAIL %s_data: got %h %h %h want 0", tag, bus.ct_data, bus.aes_blk, bus.ct_keep);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_zero("post_reset");
    endtask

    task automatic test_zero_len;
        bit saw;
        @(negedge clk);
        bus.start = 1'b1; bus.num_blocks = '0; bus.iv = {$urandom, $urandom, $urandom, $urandom};
        #1;
        vecs++;
        if (bus.done !== 1'b0) begin errs++; $display("FAIL zero_done_early: got %b want 0", bus.done); end
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        vecs++;
        if ({bus.done, bus.busy, bus.aes_req} !== 3'b100) begin
            errs++; $display("FAIL zero_done: got %b want 100", {bus.done, bus.busy, bus.aes_req});
        end
        saw = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            saw |= bus.aes_req | bus.busy | bus.done;
        end
        vecs++;
        if (saw !== 1'b0) begin errs++; $display("FAIL zero_quiet: got %b want 0", saw); end
    endtask

    task automatic test_ctr_wrap;
        logic [127:0] iv_v;
        iv_v = {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'hFFFFFFFF};
        run_msg(iv_v, 2, 0, 0, 0);
        vecs++;
        if (blk_log.size() != 2 || blk_log[1] !== {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'h0}) begin
            errs++; $display("FAIL wrap_blk1: got %h want %h", blk_log.size() > 1 ? blk_log[1] : 128'hx, {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'h0});
        end
    endtask

    task automatic test_partial;
        ks_zero = 1'b1; pt_ff = 1'b1;
        run_msg({$urandom, $urandom, $urandom, $urandom}, 1, 5, 0, 0);
        ks_zero = 1'b0; pt_ff = 1'b0;
        vecs++;
        if ({last_ct, last_keep} !== {128'hFFFFFFFFFF0000000000000000000000, 16'hF800}) begin
            errs++; $display("FAIL partial: got %h %h want FFFFFFFFFF0000000000000000000000 f800", last_ct, last_keep);
        end
    endtask

    task automatic test_backpressure;
        run_msg({$urandom, $urandom, $urandom, $urandom}, 4, 0, 10, 0);
    endtask

    task automatic test_back_to_back;
        logic [127:0] iv_v;
        for (int m = 0; m < 8; m++) begin
            iv_v = {$urandom, $urandom, $urandom, $urandom};
            if (m % 2 == 1) iv_v[31:0] = 32'hFFFFFFFF - 32'($urandom_range(0, 4));
            run_msg(iv_v, $urandom_range(1, 16), $urandom_range(0, 15), $urandom_range(0, 6), 0);
        end
    endtask

    task automatic test_abort_in_flight;
        int t;
        ks_en = 1'b0; ack_budget = 1; msg_acks = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.num_blocks = NBW'(4); bus.last_bytes = '0; bus.iv = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (msg_acks < 1 && t < 100) begin @(negedge clk); t++; end
        vecs++;
        if (msg_acks != 1) begin errs++; $display("FAIL abort_setup: got %0d acks want 1", msg_acks); end
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        #1;
        vecs++;
        if ({bus.busy, bus.ct_valid, bus.pt_ready, bus.aes_req, bus.done} !== 5'b0) begin
            errs++; $display("FAIL abort_idle: got %b want 00000", {bus.busy, bus.ct_valid, bus.pt_ready, bus.aes_req, bus.done});
        end
        bus.start = 1'b1; bus.num_blocks = NBW'(1);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        vecs++;
        if (bus.busy !== 1'b0) begin errs++; $display("FAIL abort_start_blocked: got %b want 0", bus.busy); end
        ack_budget = 1 << 30; ks_en = 1'b1;
        t = 0;
        while (pend.size() > 0 && t < 100) begin @(negedge clk); t++; end
        vecs++;
        if (pend.size() != 0) begin errs++; $display("FAIL abort_drain: got %0d pending want 0", pend.size()); end
        repeat (2) @(negedge clk);
        run_msg({$urandom, $urandom, $urandom, $urandom}, 3, 0, 0, 0);
    endtask

    task automatic test_reset_mid_run;
        run_msg({$urandom, $urandom, $urandom, $urandom}, 4, 0, 0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        bus.pt_valid = 1'b0; bus.ct_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_msg({$urandom, $urandom, $urandom, $urandom}, 4, $urandom_range(0, 15), 0, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.iv = '0; bus.num_blocks = '0; bus.last_bytes = '0;
        bus.pt_valid = 1'b0; bus.pt_data = '0; bus.ct_ready = 1'b0;
        test_reset;
        test_zero_len;
        test_ctr_wrap;
        test_partial;
        test_backpressure;
        test_back_to_back;
        test_abort_in_flight;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
